// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch sequencer.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int unsigned INST_BYTES = 4;

    // Word-aligned and inside the IMEM word range.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && (32'(addr[31:2]) < 32'(words));
    endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-to-decode valid/ready channel carrying {pc, inst}.
interface ifetch_out_if;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] inst;

    modport master (output valid, output pc, output inst, input ready);
    modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/ifetch_ctrl_fifo.sv
// Synchronous prefetch FIFO; flush overrides push and pop in the same cycle.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  T                           data_i,
    output T                           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the prefetch FIFO from IMEM,
// handles redirects, start/halt and sticky fetch faults.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter int          IMEM_WORDS = 1001
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          halt_req_i,
    input  logic          redirect_valid_i,
    input  logic [31:0]   redirect_pc_i,
    output logic [31:0]   imem_addr_o,
    input  logic [31:0]   imem_inst_i,
    ifetch_out_if.master  dec,
    output logic          busy_o,
    output logic          fault_o,
    output logic [31:0]   fault_pc_o
);
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e  state_q;
    logic [31:0]   pc_q;
    logic          busy_q, fault_q;
    logic [31:0]   fault_pc_q;

    logic          redir_acc, redir_flt, halt_acc, seq_flt, push, pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    fetch_entry_t  wr_entry, head;

    assign redir_acc = redirect_valid_i && (state_q != FAULT);
    assign redir_flt = redir_acc && !in_range(redirect_pc_i, IMEM_WORDS);
    assign halt_acc  = (state_q == FETCH) && halt_req_i;
    assign seq_flt   = (state_q == FETCH) && !redir_acc && !halt_req_i
                     && !(32'(pc_q[31:2]) < 32'(IMEM_WORDS));

    // Decode must not consume in a redirect cycle: the head is about to be flushed.
    assign dec.valid = (fifo_cnt != '0) && !redirect_valid_i;
    assign pop       = dec.ready && !fifo_empty && !redirect_valid_i;
    assign push      = (state_q == FETCH) && !redir_acc && !halt_req_i && !seq_flt
                     && (!fifo_full || pop);

    assign wr_entry    = '{pc: pc_q, inst: imem_inst_i};
    assign dec.pc      = head.pc;
    assign dec.inst    = head.inst;
    assign imem_addr_o = pc_q;
    assign busy_o      = busy_q;
    assign fault_o     = fault_q;
    assign fault_pc_o  = fault_pc_q;

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redir_acc),
        .data_i  (wr_entry),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Branch order encodes the same-cycle priority; FAULT is only left by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (redir_flt) begin
            state_q    <= FAULT;
            busy_q     <= 1'b0;
            fault_q    <= 1'b1;
            fault_pc_q <= redirect_pc_i;
        end else if (redir_acc) begin
            pc_q <= redirect_pc_i;
            if (state_q == IDLE && start_i) begin
                state_q <= FETCH;
                busy_q  <= 1'b1;
            end
        end else if (halt_acc) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else if (seq_flt) begin
            state_q    <= FAULT;
            busy_q     <= 1'b0;
            fault_q    <= 1'b1;
            fault_pc_q <= pc_q;
        end else begin
            if (push) pc_q <= pc_q + 32'(INST_BYTES);
            if (state_q == IDLE && start_i) begin
                state_q <= FETCH;
                busy_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed and randomized checks of ifetch_ctrl against a stream-level fetch model.
module tb_ifetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, halt_req = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_inst, fault_pc;
    logic        busy, fault;
    int          vectors = 0, errs = 0;

    ifetch_out_if dec_if();

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction
    assign imem_inst = imem_word(imem_addr);

    ifetch_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .halt_req_i       (halt_req),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_addr_o      (imem_addr),
        .imem_inst_i      (imem_inst),
        .dec              (dec_if),
        .busy_o           (busy),
        .fault_o          (fault),
        .fault_pc_o       (fault_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        dec_if.ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_pc, tgt;
    int          accepts;

    initial begin
        dec_if.ready = 1'b0;
        #1;
        chk("rst_valid", dec_if.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_pc", fault_pc, 0);
        chk("rst_out_pc", dec_if.pc, 0);
        chk("rst_out_inst", dec_if.inst, 0);
        chk("rst_imem_addr", imem_addr, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Streaming with decode always ready
        dec_if.ready = 1'b1; start = 1'b1;
        smp(); chk("t1_busy_idle", busy, 0);
        cyc(); start = 1'b0;
        smp(); chk("t1_busy", busy, 1); chk("t1_first_empty", dec_if.valid, 0);
        chk("t1_addr0", imem_addr, 0);
        cyc();
        for (int k = 0; k < 10; k++) begin
            smp();
            chk("t1_valid", dec_if.valid, 1);
            chk("t1_pc", dec_if.pc, 32'(4 * k));
            chk("t1_inst", dec_if.inst, imem_word(32'(4 * k)));
            cyc();
        end

        // Backpressure fills exactly DEPTH entries, then drains contiguously
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
        repeat (8) cyc();
        smp();
        chk("t2_pc_held", imem_addr, 32'h10);
        chk("t2_valid", dec_if.valid, 1);
        chk("t2_head", dec_if.pc, 0);
        cyc(); dec_if.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            smp(); chk("t2_drain_pc", dec_if.pc, 32'(4 * k));
            cyc();
        end

        // Redirect with three queued entries
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        smp(); chk("t3_three_pushed", imem_addr, 32'hC);
        redirect_valid = 1'b1; redirect_pc = 32'h60; dec_if.ready = 1'b1;
        #1; chk("t3_valid_redir", dec_if.valid, 0);
        cyc(); redirect_valid = 1'b0;
        smp(); chk("t3_valid_after", dec_if.valid, 0); chk("t3_addr", imem_addr, 32'h60);
        cyc();
        smp(); chk("t3_tgt_valid", dec_if.valid, 1); chk("t3_tgt_pc", dec_if.pc, 32'h60);
        chk("t3_tgt_inst", dec_if.inst, imem_word(32'h60));
        cyc();
        smp(); chk("t3_next_pc", dec_if.pc, 32'h64);
        cyc();

        // Misaligned redirect faults and locks out further control
        redirect_valid = 1'b1; redirect_pc = 32'h62;
        smp(); chk("t4_valid_redir", dec_if.valid, 0);
        cyc(); redirect_valid = 1'b0;
        smp(); chk("t4_fault", fault, 1); chk("t4_fault_pc", fault_pc, 32'h62);
        chk("t4_empty", dec_if.valid, 0); chk("t4_busy", busy, 0);
        cyc();
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc(); start = 1'b0; redirect_valid = 1'b0;
        cyc();
        smp(); chk("t4_sticky_pc", fault_pc, 32'h62); chk("t4_sticky_busy", busy, 0);
        chk("t4_sticky_fault", fault, 1); chk("t4_sticky_valid", dec_if.valid, 0);
        rst_n = 1'b0; #1;
        chk("t4_rst_fault", fault, 0); chk("t4_rst_fault_pc", fault_pc, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFA4; cyc(); redirect_valid = 1'b0;
        smp(); chk("t4_range_fault", fault, 1); chk("t4_range_pc", fault_pc, 32'hFA4);
        cyc();

        // Last valid word is fetched, then the sequential range check faults
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFA0; cyc(); redirect_valid = 1'b0;
        cyc(); cyc();
        smp(); chk("t4s_fault", fault, 1); chk("t4s_fault_pc", fault_pc, 32'hFA4);
        chk("t4s_drain_valid", dec_if.valid, 1); chk("t4s_drain_pc", dec_if.pc, 32'hFA0);
        chk("t4s_drain_inst", dec_if.inst, imem_word(32'hFA0));
        cyc(); dec_if.ready = 1'b1;
        smp(); chk("t4s_still_head", dec_if.valid, 1);
        cyc();
        smp(); chk("t4s_drained", dec_if.valid, 0);
        cyc();

        // Halt with a full FIFO: drain only, then resume at the held PC
        do_reset();
        start = 1'b1; cyc(); start = 1'b0;
        repeat (6) cyc();
        halt_req = 1'b1; dec_if.ready = 1'b1;
        smp(); chk("t5_head", dec_if.pc, 0); chk("t5_valid", dec_if.valid, 1);
        cyc(); halt_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            smp(); chk("t5_drain_pc", dec_if.pc, 32'(4 * k)); chk("t5_busy", busy, 0);
            cyc();
        end
        smp(); chk("t5_empty", dec_if.valid, 0); chk("t5_pc_held", imem_addr, 32'h10);
        cyc(); cyc(); cyc();
        smp(); chk("t5_no_push", dec_if.valid, 0);
        start = 1'b1; cyc(); start = 1'b0;
        smp(); chk("t5_resume_busy", busy, 1);
        cyc();
        smp(); chk("t5_resume_valid", dec_if.valid, 1); chk("t5_resume_pc", dec_if.pc, 32'h10);
        cyc();

        // Asynchronous reset between edges
        do_reset();
        dec_if.ready = 1'b1; start = 1'b1; cyc(); start = 1'b0;
        repeat (4) cyc();
        smp(); chk("t6_streaming", dec_if.valid, 1);
        #1 rst_n = 1'b0; #1;
        chk("t6_valid", dec_if.valid, 0); chk("t6_pc", imem_addr, 0);
        chk("t6_busy", busy, 0); chk("t6_fault", fault, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Randomized control: accepted stream must follow redirect targets contiguously
        exp_pc = 32'h0; accepts = 0;
        start = 1'b1; cyc();
        for (int n = 0; n < 1500; n++) begin
            start          = ($urandom % 8) == 0;
            halt_req       = ($urandom % 24) == 0;
            dec_if.ready   = ($urandom % 4) != 0;
            redirect_valid = (($urandom % 16) == 0) || (exp_pc > 32'hE00);
            tgt            = 32'($urandom_range(0, 900)) * 4;
            redirect_pc    = tgt;
            smp();
            if (redirect_valid) begin
                chk("rnd_redir_valid", dec_if.valid, 0);
                exp_pc = tgt;
            end else if (dec_if.valid && dec_if.ready) begin
                chk("rnd_pc", dec_if.pc, exp_pc);
                chk("rnd_inst", dec_if.inst, imem_word(exp_pc));
                exp_pc = exp_pc + 4;
                accepts++;
            end
            cyc();
        end
        start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        chk("rnd_progress", 32'(accepts > 200), 1);
        chk("rnd_no_fault", fault, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
